// File: rtl/hex_cmd_pkg.sv
// hex_cmd_pkg: shared constants and state encodings for the hex command codec.
//   ASCII framing bytes, error codes, RX and TX FSM state types.
package hex_cmd_pkg;

    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] SP  = 8'h20;
    localparam logic [7:0] TAB = 8'h09;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CHAR = 2'd1;
    localparam logic [1:0] ERR_OVF  = 2'd2;

    typedef enum logic [1:0] {R_ACC, R_DISCARD, R_PUSH} rx_state_e;
    typedef enum logic [1:0] {T_IDLE, T_HEX, T_EOL} tx_state_e;

endpackage

// File: rtl/hex_char_conv.sv
// hex_char_conv: combinational ASCII <-> hex nibble conversion.
//   ascii_i  -> is_hex_o, nibble_o : classify a byte and decode its digit value
//   nibble_i -> ascii_o            : encode a nibble, case chosen by P_UPPERCASE
module hex_char_conv #(
    parameter bit P_UPPERCASE = 1'b1
) (
    input  logic [7:0] ascii_i,
    output logic       is_hex_o,
    output logic [3:0] nibble_o,
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    logic       is_dig;
    logic       is_af;
    logic [7:0] lc;

    // Folding bit 5 maps 'A'-'F' onto 'a'-'f' so one range test covers both cases.
    assign lc       = ascii_i | 8'h20;
    assign is_dig   = (ascii_i >= 8'h30) && (ascii_i <= 8'h39);
    assign is_af    = (lc >= 8'h61) && (lc <= 8'h66);
    assign is_hex_o = is_dig || is_af;
    // Low nibble of 'A'/'a' is 1, so adding 9 yields 10..15.
    assign nibble_o = is_dig ? ascii_i[3:0] : (is_af ? ascii_i[3:0] + 4'd9 : 4'd0);
    assign ascii_o  = (nibble_i < 4'd10) ? {4'h3, nibble_i}
                    : (P_UPPERCASE ? 8'h37 : 8'h57) + {4'h0, nibble_i};

endmodule

// File: rtl/hex_cmd_codec.sv
// hex_cmd_codec: ASCII hex command parser (RX) and hex response renderer (TX).
//   rx_*  : ASCII bytes in (valid/ready)      cmd_* : assembled command words out
//   rsp_* : response words in (valid/ready)   tx_*  : ASCII bytes out
//   err_* : error strobe, last error code, saturating error count
module hex_cmd_codec
    import hex_cmd_pkg::*;
#(
    parameter int P_WORD_W    = 32,
    parameter bit P_UPPERCASE = 1'b1,
    parameter int P_TX_EOL    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data_i,
    input  logic                rx_valid_i,
    output logic                rx_ready_o,
    output logic [P_WORD_W-1:0] cmd_data_o,
    output logic                cmd_valid_o,
    input  logic                cmd_ready_i,
    input  logic [P_WORD_W-1:0] rsp_data_i,
    input  logic                rsp_valid_i,
    output logic                rsp_ready_o,
    output logic [7:0]          tx_data_o,
    output logic                tx_valid_o,
    input  logic                tx_ready_i,
    output logic                err_pulse_o,
    output logic [1:0]          err_code_o,
    output logic [7:0]          err_count_o
);

    localparam int N  = P_WORD_W / 4;
    localparam int CW = $clog2(N + 1);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    rx_state_e           rx_state_q, rx_state_d;
    logic [P_WORD_W-1:0] acc_q, acc_d, cmd_data_q, cmd_data_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                cmd_valid_q, cmd_valid_d, err_pulse_q, err_pulse_d;
    logic [1:0]          err_code_q, err_code_d;
    logic [7:0]          err_count_q, err_count_d;
    logic                rx_fire, rx_is_hex, rx_is_ws, rx_is_term;
    logic [3:0]          rx_nibble;
    logic [7:0]          rx_ascii_unused;

    tx_state_e           tx_state_q, tx_state_d;
    logic [P_WORD_W-1:0] word_q, word_d, tx_next;
    logic [IW-1:0]       idx_q, idx_d;
    logic [7:0]          tx_data_q, tx_data_d, tx_ascii;
    logic                tx_valid_q, tx_valid_d, tx_fire;
    logic                tx_is_hex_unused;
    logic [3:0]          tx_nibble_unused;

    hex_char_conv #(.P_UPPERCASE(P_UPPERCASE)) u_rx_conv (
        .ascii_i (rx_data_i),
        .is_hex_o(rx_is_hex),
        .nibble_o(rx_nibble),
        .nibble_i(4'h0),
        .ascii_o (rx_ascii_unused)
    );

    hex_char_conv #(.P_UPPERCASE(P_UPPERCASE)) u_tx_conv (
        .ascii_i (8'h00),
        .is_hex_o(tx_is_hex_unused),
        .nibble_o(tx_nibble_unused),
        .nibble_i(tx_next[P_WORD_W-1 -: 4]),
        .ascii_o (tx_ascii)
    );

    // Ready strobes are gated by rst so they read 0 while reset is held.
    assign rx_ready_o  = !rst && (rx_state_q != R_PUSH);
    assign rsp_ready_o = !rst && (tx_state_q == T_IDLE);
    assign rx_fire     = rx_valid_i && rx_ready_o;
    assign rx_is_ws    = (rx_data_i == SP) || (rx_data_i == TAB);
    assign rx_is_term  = (rx_data_i == CR) || (rx_data_i == LF);
    assign tx_fire     = tx_valid_q && tx_ready_i;
    // The word is shifted left per digit so the next digit is always the top nibble.
    assign tx_next     = (tx_state_q == T_IDLE) ? rsp_data_i : word_q << 4;

    assign cmd_data_o  = cmd_data_q;
    assign cmd_valid_o = cmd_valid_q;
    assign tx_data_o   = tx_data_q;
    assign tx_valid_o  = tx_valid_q;
    assign err_pulse_o = err_pulse_q;
    assign err_code_o  = err_code_q;
    assign err_count_o = err_count_q;

    always_comb begin
        rx_state_d  = rx_state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = cmd_valid_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        case (rx_state_q)
            R_ACC: if (rx_fire) begin
                if (rx_is_hex && cnt_q < CW'(N)) begin
                    acc_d = (acc_q << 4) | P_WORD_W'(rx_nibble);
                    cnt_d = cnt_q + CW'(1);
                end else if (rx_is_hex) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_OVF;
                    rx_state_d  = R_DISCARD;
                end else if (rx_is_term && cnt_q != '0) begin
                    cmd_data_d  = acc_q;
                    cmd_valid_d = 1'b1;
                    rx_state_d  = R_PUSH;
                end else if (!rx_is_term && !rx_is_ws) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = ERR_CHAR;
                    rx_state_d  = R_DISCARD;
                end
            end
            R_DISCARD: if (rx_fire && rx_is_term) begin
                acc_d      = '0;
                cnt_d      = '0;
                rx_state_d = R_ACC;
            end
            R_PUSH: if (cmd_ready_i) begin
                cmd_valid_d = 1'b0;
                acc_d       = '0;
                cnt_d       = '0;
                rx_state_d  = R_ACC;
            end
            default: rx_state_d = R_ACC;
        endcase
        err_count_d = (err_pulse_d && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q  <= R_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_count_q <= 8'd0;
        end else begin
            rx_state_q  <= rx_state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        word_d     = word_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        case (tx_state_q)
            T_IDLE: if (rsp_valid_i) begin
                word_d     = tx_next;
                idx_d      = IW'(N - 1);
                tx_data_d  = tx_ascii;
                tx_valid_d = 1'b1;
                tx_state_d = T_HEX;
            end
            T_HEX: if (tx_fire) begin
                if (idx_q != '0) begin
                    word_d    = tx_next;
                    idx_d     = idx_q - IW'(1);
                    tx_data_d = tx_ascii;
                end else if (P_TX_EOL == 0) begin
                    tx_valid_d = 1'b0;
                    tx_state_d = T_IDLE;
                end else begin
                    tx_data_d  = (P_TX_EOL == 2) ? CR : LF;
                    tx_state_d = T_EOL;
                end
            end
            // Only CR or LF is ever presented here, so the byte itself tracks progress.
            T_EOL: if (tx_fire) begin
                if (tx_data_q == CR) begin
                    tx_data_d = LF;
                end else begin
                    tx_valid_d = 1'b0;
                    tx_state_d = T_IDLE;
                end
            end
            default: tx_state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= T_IDLE;
            word_q     <= '0;
            idx_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            word_q     <= word_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

endmodule
